// File: rtl/aemb_pkg.sv
// Shared definitions for the AEMB pipeline sequencer: state encoding and
// branch flush depths.
package aemb_pkg;

    typedef enum logic [2:0] {
        AEMB_PS_RST   = 3'd0,
        AEMB_PS_FILL  = 3'd1,
        AEMB_PS_RUN   = 3'd2,
        AEMB_PS_DWAIT = 3'd3,
        AEMB_PS_FLUSH = 3'd4
    } aemb_ps_e;

    // Fetch bubbles injected after a taken branch.
    localparam logic [1:0] AEMB_FL_NODLY = 2'd2;
    localparam logic [1:0] AEMB_FL_DLY   = 2'd1;

endpackage

// File: rtl/aemb_bus_tmo.sv
// Data-bus wait timeout counter. Counts while enabled, clear has priority,
// and expire_o flags the wait cycle whose increment would reach all-ones.
module aemb_bus_tmo #(
    parameter int unsigned TMO_W = 8
) (
    input  logic nclk,
    input  logic nrst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TMO_W-1:0] LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

    always_ff @(negedge nclk) begin
        if (nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aemb_pipe_ctrl.sv
// AEMB pipeline sequencer: ordered reset release, data-bus stall with
// timeout, and fetch bubbles on instruction wait and taken branches.
module aemb_pipe_ctrl
    import aemb_pkg::*;
#(
    parameter int unsigned RST_CYC = 4,
    parameter int unsigned TMO_W   = 8
) (
    input  logic     nclk,
    input  logic     nrst,
    input  logic     iwb_ack_i,
    input  logic     dwb_stb_i,
    input  logic     dwb_ack_i,
    input  logic     bra_i,
    input  logic     dly_i,
    output logic     frst,
    output logic     drst,
    output logic     frun,
    output logic     drun,
    output logic     xrun,
    output logic     pipe_ce_o,
    output logic     stall_o,
    output logic     bus_err_o,
    output aemb_ps_e state_o
);

    localparam logic [3:0] RST_LAST = 4'(RST_CYC - 1);

    aemb_ps_e   state_q, state_d;
    logic [3:0] rst_cnt_q, rst_cnt_d;
    logic [1:0] fl_cnt_q, fl_cnt_d;
    logic       slot_q, slot_d;
    logic       frst_q, frst_d, drst_q, drst_d;
    logic       frun_q, frun_d, drun_q, drun_d, xrun_q, xrun_d;
    logic       pce_q, pce_d, stall_q, stall_d, berr_q, berr_d;
    logic       dwait;
    logic       tmo_exp;

    // Data bus: an access is outstanding while dwb_stb_i is high and
    // dwb_ack_i is low; the cycle with both high completes it.
    assign dwait = dwb_stb_i && !dwb_ack_i;

    aemb_bus_tmo #(.TMO_W(TMO_W)) u_tmo (
        .nclk     (nclk),
        .nrst     (nrst),
        .clr_i    ((state_q != AEMB_PS_DWAIT) || dwb_ack_i || tmo_exp),
        .en_i     (state_q == AEMB_PS_DWAIT),
        .expire_o (tmo_exp)
    );

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        fl_cnt_d  = fl_cnt_q;
        slot_d    = slot_q;
        frst_d    = frst_q;
        drst_d    = drst_q;
        frun_d    = frun_q;
        drun_d    = drun_q;
        xrun_d    = xrun_q;
        pce_d     = pce_q;
        stall_d   = 1'b0;
        berr_d    = 1'b0;
        case (state_q)
            AEMB_PS_RST: begin
                {frst_d, drst_d, frun_d, drun_d, xrun_d, pce_d} = '0;
                rst_cnt_d = rst_cnt_q + 1'b1;
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = AEMB_PS_FILL;
                    rst_cnt_d = '0;
                end
            end
            AEMB_PS_FILL: begin
                frst_d  = 1'b1;
                drst_d  = 1'b0;
                pce_d   = 1'b1;
                frun_d  = 1'b1;
                state_d = AEMB_PS_RUN;
            end
            AEMB_PS_RUN: begin
                {frst_d, drst_d, pce_d, drun_d, xrun_d} = '1;
                frun_d = iwb_ack_i;
                if (dwait) begin
                    state_d = AEMB_PS_DWAIT;
                end else if (slot_q) begin
                    // Delay-slot instruction has advanced; now drop one fetch.
                    state_d  = AEMB_PS_FLUSH;
                    fl_cnt_d = AEMB_FL_DLY;
                    slot_d   = 1'b0;
                end else if (bra_i) begin
                    if (dly_i) begin
                        slot_d = 1'b1;
                    end else begin
                        state_d  = AEMB_PS_FLUSH;
                        fl_cnt_d = AEMB_FL_NODLY;
                    end
                end
            end
            AEMB_PS_DWAIT: begin
                pce_d   = 1'b0;
                stall_d = 1'b1;
                if (dwb_ack_i || tmo_exp) begin
                    berr_d  = !dwb_ack_i;
                    state_d = (fl_cnt_q != 2'd0) ? AEMB_PS_FLUSH : AEMB_PS_RUN;
                end
            end
            AEMB_PS_FLUSH: begin
                pce_d  = 1'b1;
                frun_d = 1'b0;
                drun_d = 1'b1;
                xrun_d = 1'b1;
                if (dwait) begin
                    state_d = AEMB_PS_DWAIT;
                end else if (fl_cnt_q == 2'd1) begin
                    state_d  = AEMB_PS_RUN;
                    fl_cnt_d = 2'd0;
                end else begin
                    fl_cnt_d = fl_cnt_q - 2'd1;
                end
            end
            default: state_d = AEMB_PS_RST;
        endcase
    end

    always_ff @(negedge nclk) begin
        if (nrst) begin
            state_q   <= AEMB_PS_RST;
            rst_cnt_q <= '0;
            fl_cnt_q  <= '0;
            slot_q    <= 1'b0;
            frst_q    <= 1'b0;
            drst_q    <= 1'b0;
            frun_q    <= 1'b0;
            drun_q    <= 1'b0;
            xrun_q    <= 1'b0;
            pce_q     <= 1'b0;
            stall_q   <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            fl_cnt_q  <= fl_cnt_d;
            slot_q    <= slot_d;
            frst_q    <= frst_d;
            drst_q    <= drst_d;
            frun_q    <= frun_d;
            drun_q    <= drun_d;
            xrun_q    <= xrun_d;
            pce_q     <= pce_d;
            stall_q   <= stall_d;
            berr_q    <= berr_d;
        end
    end

    assign frst      = frst_q;
    assign drst      = drst_q;
    assign frun      = frun_q;
    assign drun      = drun_q;
    assign xrun      = xrun_q;
    assign pipe_ce_o = pce_q;
    assign stall_o   = stall_q;
    assign bus_err_o = berr_q;
    assign state_o   = state_q;

endmodule

// File: doc/aemb_pipe_ctrl.md
# aemb_pipe_ctrl

Pipeline sequencer for the AEMB core. It owns stage resets, per-stage run enables and the global pipeline hold that drive the fetch/decode/execute stages. It brings the pipeline out of reset in a fixed order and freezes the pipeline while a data-bus access is outstanding, with a timeout and error flag. It injects fetch bubbles on instruction-bus wait and on taken branches, honouring the delay slot.

## Interface
- `RST_CYC`, default 4: cycles the stage resets stay asserted after `nrst` deasserts (1..15).
- `TMO_W`, default 8: width of the data-bus timeout counter. Timeout fires after 2^TMO_W−1 wait cycles.

Ports:
- `nclk` in 1: core clock. All state updates on the falling edge, same as the pipeline.
- `nrst` in 1: reset, synchronous, active-high. The port keeps the codebase name; polarity and synchronicity are fixed.
- `iwb_ack_i` in 1: instruction-bus acknowledge for the current fetch.
- `dwb_stb_i` in 1: data-bus strobe from the decode stage.
- `dwb_ack_i` in 1: data-bus acknowledge.
- `bra_i` in 1: branch taken (decode-stage branch flag).
- `dly_i` in 1: branch has a delay slot.
- `frst` out 1: fetch-stage reset, active-low.
- `drst` out 1: decode-stage reset, active-low.
- `frun` out 1: fetch advance. Low makes fetch load a NOP bubble.
- `drun` out 1: decode advance. Low makes decode load a bubble.
- `xrun` out 1: execute advance.
- `pipe_ce_o` out 1: global hold. Low freezes every pipeline register.
- `stall_o` out 1: high while in DWAIT.
- `bus_err_o` out 1: one-cycle pulse on data-bus timeout.

## Operation
- All outputs are registered. Reset values: `frst`=0, `drst`=0, `frun`=0, `drun`=0, `xrun`=0, `pipe_ce_o`=0, `stall_o`=0, `bus_err_o`=0. State=RST, counters=0.
- **RST**
  - Outputs hold their reset values.
  - `rst_cnt` counts up each cycle with `nrst`=0.
  - When `rst_cnt`==RST_CYC−1: go to FILL.
- **FILL** (exactly 1 cycle)
  - `frst`=1, `drst`=0, `pipe_ce_o`=1, `frun`=1.
  - Then go to RUN.
- **RUN**
  - `frst`=`drst`=1, `pipe_ce_o`=1, `drun`=`xrun`=1, `frun`=`iwb_ack_i`.
  - Priority per cycle, highest first:
    1. `dwb_stb_i`=1 and `dwb_ack_i`=0: go to DWAIT.
    2. `bra_i`=1: go to FLUSH, with `fl_cnt`=2 if `dly_i`=0, else 1 after one slot cycle in RUN.
    3. Otherwise stay in RUN.
- **DWAIT**
  - `pipe_ce_o`=0, `stall_o`=1. Run enables keep their last values (they are frozen anyway).
  - `tmo_cnt` increments each cycle.
  - `dwb_ack_i`=1: clear `tmo_cnt`, go to RUN.
  - `tmo_cnt` all-ones without ack: `bus_err_o`=1 for one cycle, clear `tmo_cnt`, go to RUN (access abandoned).
  - Ack and timeout in the same cycle: ack wins, no error.
- **FLUSH**
  - `pipe_ce_o`=1, `frun`=0, `drun`=1, `xrun`=1.
  - `fl_cnt` decrements; at 1, go to RUN.
  - A data-bus wait during FLUSH goes to DWAIT and the remaining flush count is kept. On exit from DWAIT, return to FLUSH rather than RUN.
- **Branch during DWAIT**: the pipeline is frozen, so `bra_i` stays valid. It is serviced on the first cycle back in RUN.
- **Delay slot**: with `dly_i`=1, the cycle after `bra_i` is a normal RUN cycle (slot instruction advances), followed by 1 FLUSH cycle.
- **`nrst`=1 in any state**: next state is RST, all outputs and counters return to their reset values on the next edge. This takes priority over everything else.

## Timing
- Reset release to first `frun`=1: RST_CYC+1 edges. `drst` rises one edge after `frst`.
- Data stall: `pipe_ce_o` falls on the edge after `dwb_stb_i`∧¬`dwb_ack_i` is sampled. It rises on the edge after ack.
- Taken branch, no delay: exactly 2 cycles of `frun`=0, starting the edge after `bra_i`.
- Taken branch with delay: 1 slot cycle, then 1 cycle of `frun`=0.
- `bus_err_o` is high for exactly 1 cycle, 2^TMO_W−1 cycles after DWAIT entry.

## Structure
- Shared package `aemb_pkg`:
  - state encoding `AEMB_PS_RST`, `AEMB_PS_FILL`, `AEMB_PS_RUN`, `AEMB_PS_DWAIT`, `AEMB_PS_FLUSH`;
  - flush depth constants `AEMB_FL_NODLY`=2 and `AEMB_FL_DLY`=1.
- One sub-module is natural: `aemb_bus_tmo`, the TMO_W-wide timeout counter with clear/enable/expire.

## Test plan
- RST_CYC=4; `nrst` high 3 cycles, then low → `frst` rises at edge 5, `drst` at edge 6, `frun`=1 from edge 5.
- RUN; `dwb_stb_i`=1, `dwb_ack_i` low 3 cycles then high → `pipe_ce_o`=0 for 3 cycles, `stall_o` matches, `bus_err_o` stays 0.
- TMO_W=4; `dwb_stb_i`=1, no ack → `bus_err_o` pulses at wait cycle 15, then RUN. Repeat with ack at cycle 15 → no pulse.
- `bra_i`=1, `dly_i`=0 in RUN → `frun`=0 for 2 cycles. Same with `dly_i`=1 → 1 RUN slot cycle, then `frun`=0 for 1 cycle.
- `bra_i`=1 coincident with a data stall → DWAIT first; the branch flush starts the cycle after ack.
- `nrst` asserted mid-DWAIT with `tmo_cnt`=7 → next edge: all outputs 0, state RST, counters 0, no `bus_err_o`.
